// File: rtl/piso_shift_ctrl.sv
// Parallel-in/serial-out shifter that streams one word per valid/ready handshake.
// Bit order is set by MSB_FIRST, and back-to-back words are supported without gaps.
module piso_shift_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [CNT_W-1:0] cnt;
  logic             final_bit;
  logic             accept;

  assign final_bit = (cnt == CNT_ZERO);

  // The final bit of a word can be replaced by a new word on the same edge,
  // which is what allows words to follow each other with no idle cycle.
  assign load_ready = (state == IDLE) || ((state == SHIFT) && final_bit && enable);
  assign accept     = load_valid && load_ready;

  assign busy      = (state == SHIFT);
  assign out_valid = busy;
  assign out       = out_valid ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : 1'b0;
  assign last      = out_valid && final_bit;

  always_comb begin
    sr_shifted = sr;
    if (MSB_FIRST) begin
      sr_shifted = {sr[WIDTH-2:0], 1'b0};
    end else begin
      sr_shifted = {1'b0, sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      sr    <= data;
      cnt   <= CNT_FIRST;
    end else if (state == SHIFT && enable) begin
      if (!final_bit) begin
        sr  <= sr_shifted;
        cnt <= cnt - CNT_ONE;
      end else begin
        state <= IDLE;
        sr    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Exercises three shifter configurations side by side against a word-level model
// that indexes the stored word by bit position instead of shifting it.
module tb_piso_shift_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       load_valid;
  logic [7:0] data;

  logic ready_o [3];
  logic out_o   [3];
  logic valid_o [3];
  logic last_o  [3];
  logic busy_o  [3];

  int checks = 0;
  int errors = 0;

  // Reference model: instance 0 = 4-bit LSB first, 1 = 4-bit MSB first, 2 = 8-bit LSB first
  int         wid [3] = '{4, 4, 8};
  bit         msb [3] = '{1'b0, 1'b1, 1'b0};
  bit         busy_m [3];
  logic [7:0] word_m [3];
  int         idx_m  [3];
  logic       smp_out [3];

  piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l4 (
    .clk(clk), .reset(reset), .enable(enable), .data(data[3:0]),
    .load_valid(load_valid), .load_ready(ready_o[0]), .out(out_o[0]),
    .out_valid(valid_o[0]), .last(last_o[0]), .busy(busy_o[0])
  );

  piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
    .clk(clk), .reset(reset), .enable(enable), .data(data[3:0]),
    .load_valid(load_valid), .load_ready(ready_o[1]), .out(out_o[1]),
    .out_valid(valid_o[1]), .last(last_o[1]), .busy(busy_o[1])
  );

  piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
    .clk(clk), .reset(reset), .enable(enable), .data(data),
    .load_valid(load_valid), .load_ready(ready_o[2]), .out(out_o[2]),
    .out_valid(valid_o[2]), .last(last_o[2]), .busy(busy_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic expOut(int i);
    int pos;
    pos = msb[i] ? (wid[i] - 1 - idx_m[i]) : idx_m[i];
    return busy_m[i] ? word_m[i][pos] : 1'b0;
  endfunction

  function automatic logic expReady(int i);
    return !busy_m[i] || (idx_m[i] == wid[i] - 1 && enable);
  endfunction

  // One clock cycle: drive on the falling edge, check mid-cycle, advance the model on the rising edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic lv, input logic [7:0] d);
    logic rdy [3];
    @(negedge clk);
    reset      = rst;
    enable     = en;
    load_valid = lv;
    data       = d;
    #1;
    for (int i = 0; i < 3; i++) begin
      smp_out[i] = out_o[i];
      rdy[i]     = expReady(i);
      checkOutput($sformatf("out[%0d]", i),        32'(out_o[i]),   32'(expOut(i)));
      checkOutput($sformatf("out_valid[%0d]", i),  32'(valid_o[i]), 32'(busy_m[i]));
      checkOutput($sformatf("busy[%0d]", i),       32'(busy_o[i]),  32'(busy_m[i]));
      checkOutput($sformatf("last[%0d]", i),       32'(last_o[i]),
                  32'(busy_m[i] && idx_m[i] == wid[i] - 1));
      checkOutput($sformatf("load_ready[%0d]", i), 32'(ready_o[i]), 32'(rdy[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        busy_m[i] = 1'b0;
        idx_m[i]  = 0;
      end else if (lv && rdy[i]) begin
        busy_m[i] = 1'b1;
        word_m[i] = d;
        idx_m[i]  = 0;
      end else if (busy_m[i] && en) begin
        if (idx_m[i] == wid[i] - 1) busy_m[i] = 1'b0;
        else idx_m[i]++;
      end
    end
  endtask

  initial begin
    logic [3:0] bits_l4;
    logic [3:0] bits_m4;
    logic [7:0] bits_l8;
    int         busy_cycles;

    for (int i = 0; i < 3; i++) begin
      busy_m[i] = 1'b0;
      word_m[i] = '0;
      idx_m[i]  = 0;
    end
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; data = '0;
    repeat (2) @(posedge clk);

    $display("[TB] single word, both bit orders");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0D);
    busy_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      bits_l4[k] = smp_out[0];
      bits_m4[k] = smp_out[1];
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("s1_lsb_bits", 32'(bits_l4), 32'h0000000D);
    checkOutput("s2_msb_bits", 32'(bits_m4), 32'h0000000B);

    $display("[TB] back-to-back words");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0D);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b1, 8'h06);
    for (int k = 0; k < 9; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    $display("[TB] stall mid-word");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0D);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h0F);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    $display("[TB] reset mid-word");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0D);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h0F);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("s5_idle_after_reset", 32'(busy_o[0]), 32'h0);

    $display("[TB] 8-bit words");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, (k == 7), 8'hFF);
      bits_l8[k] = smp_out[2];
      if (busy_o[2]) busy_cycles++;
    end
    checkOutput("s6_a5_bits", 32'(bits_l8), 32'h000000A5);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      bits_l8[k] = smp_out[2];
    end
    checkOutput("s6_ff_bits", 32'(bits_l8), 32'h000000FF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)),
                    8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_ctrl.md
Name: piso_shift_ctrl

Overview:
Parametrised parallel-in/serial-out shifter with valid/ready load handshake, selectable bit order, shift stall and back-to-back word streaming. It succeeds the fixed 4-bit PISO and feeds operand bits to the serial adder datapath. One word is accepted per handshake and emitted one bit per enabled clock. A `last` flag marks the final bit of each word.

Parameters:
WIDTH, 4, word width in bits; legal range is 2 or more.
MSB_FIRST, 0, 0 shifts out LSB first; 1 shifts out MSB first.
CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  shift gate; when 0 in SHIFT, all state holds.
data  in  WIDTH  parallel word to serialise.
load_valid  in  1  `data` is valid and offered for loading.
load_ready  out  1  block can accept a word this cycle.
out  out  1  current serial bit; 0 when out_valid=0.
out_valid  out  1  `out` carries a live bit.
last  out  1  `out` is the final bit of the current word.
busy  out  1  a word is in flight (state is SHIFT).

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE, sr=0, cnt=0.
  - Outputs: out=0, out_valid=0, last=0, busy=0, load_ready=1.
  - Reset overrides everything. A word in flight is discarded, and a coincident load is ignored.
- Registers: sr[WIDTH-1:0], cnt[CNT_W-1:0], state in {IDLE, SHIFT}.
- Combinational outputs:
  - out_valid = busy = (state==SHIFT).
  - out = out_valid ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : 0.
  - last = out_valid && cnt==0.
  - load_ready = (state==IDLE) || (state==SHIFT && cnt==0 && enable).
- Load (load_valid && load_ready at an edge):
  - sr<=data, cnt<=WIDTH-1, state<=SHIFT.
  - The first bit appears on `out` in the cycle after the accepting edge (1-cycle latency).
- IDLE:
  - Load is accepted regardless of `enable`.
  - With no load, state is held.
- SHIFT, enable=1, cnt!=0:
  - LSB_first: sr<=sr>>1. MSB_first: sr<=sr<<1. Vacated bit is filled with 0.
  - cnt<=cnt-1.
- SHIFT, enable=1, cnt==0 (final bit consumed):
  - If load_valid: reload per the load rule and stay in SHIFT. There is no gap, so the new word's first bit follows the old word's last bit on the next cycle.
  - Otherwise: state<=IDLE, sr<=0.
- SHIFT, enable=0:
  - sr, cnt and state hold.
  - out, out_valid and last are stable; the bit repeats.
  - load_ready=0, so loads are not accepted.
- Timing: a word occupies exactly WIDTH enabled cycles in SHIFT. Throughput is one word per WIDTH enabled cycles when load_valid is held high.
- Handshake rule: `data` is sampled only on an accepting edge. Changes to `data` while busy have no effect on the word in flight.
- load_valid may drop without acceptance; no state change results.

Test Plan:
1. WIDTH=4, MSB_FIRST=0: reset 1 cycle, then data=4'b1101, load_valid 1 cycle, enable=1 -> out=1,0,1,1 on the next 4 cycles; last=1 on the 4th; then out_valid=0, load_ready=1.
2. Same word with MSB_FIRST=1 -> out=1,1,0,1; last on the 4th bit; busy=1 for exactly 4 cycles.
3. Back-to-back: load 4'b1101, hold load_valid=1, change data to 4'b0110 at the first-bit cycle -> out=1,0,1,1,0,1,1,0 (LSB first) with no idle cycle between words; out_valid stays high for 8 cycles; last is high at bits 4 and 8.
4. Stall: load 4'b1101 LSB first; drop enable for 3 cycles after the 2nd bit -> out holds 0 with out_valid=1 for those cycles, load_ready=0 even with load_valid=1; then resumes 1,1; total 7 busy cycles.
5. Reset mid-word: load 4'b1101; assert reset after the 2nd bit while load_valid=1 with 4'b1111 -> next cycle out=0, out_valid=0, busy=0, load_ready=1; the 4'b1111 word is not loaded.
6. WIDTH=8, MSB_FIRST=0, data=8'hA5, enable=1 -> out=1,0,1,0,0,1,0,1; last on the 8th bit; cnt wraps cleanly for a second load of 8'hFF, giving eight 1s.
